// File: rtl/exec_pkg.sv
// Shared definitions for the execute result stage: MIPS funct codes and FSM states.
package exec_pkg;

  localparam int unsigned FN_W = 6;

  localparam logic [FN_W-1:0] FN_ADD   = 6'd32;
  localparam logic [FN_W-1:0] FN_SUB   = 6'd34;
  localparam logic [FN_W-1:0] FN_AND   = 6'd36;
  localparam logic [FN_W-1:0] FN_OR    = 6'd37;
  localparam logic [FN_W-1:0] FN_SLT   = 6'd42;
  localparam logic [FN_W-1:0] FN_SRL   = 6'd2;
  localparam logic [FN_W-1:0] FN_MULTU = 6'd25;
  localparam logic [FN_W-1:0] FN_MFHI  = 6'd16;
  localparam logic [FN_W-1:0] FN_MFLO  = 6'd18;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

endpackage

// File: rtl/multu_seq.sv
// Sequential unsigned shift-add multiplier datapath, one iteration per step cycle.
// The next-product and last-iteration strobe are exposed combinationally so the
// owner can capture the final product on the same edge as the last iteration.
module multu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 last_c,
  output logic [2*WIDTH-1:0]   product_c
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned PROD_W = 2 * WIDTH + 1;

  logic [WIDTH-1:0]  mcand;
  logic [PROD_W-1:0] prod;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  addend;
  logic [WIDTH:0]    sum;
  logic [PROD_W-1:0] prod_nxt;

  // Upper WIDTH+1 bits keep the carry, so nothing is lost before the shift.
  always_comb begin
    addend    = prod[0] ? mcand : '0;
    sum       = prod[PROD_W-1:WIDTH] + {1'b0, addend};
    prod_nxt  = {1'b0, sum, prod[WIDTH-1:1]};
    product_c = prod_nxt[2*WIDTH-1:0];
    last_c    = step && (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      prod  <= '0;
      cnt   <= '0;
    end else if (start) begin
      mcand <= a;
      prod  <= {(WIDTH + 1)'(0), b};
      cnt   <= '0;
    end else if (step) begin
      prod  <= prod_nxt;
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/exec_result_stage.sv
// Execute-stage result register: selects ALU/shifter/HI/LO results and sequences
// a MULTU through multu_seq into the architectural HI/LO pair.
module exec_result_stage
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FN_W-1:0]   Signal,
  input  logic              valid_in,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic [WIDTH-1:0]  shift_result,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  dataout,
  output logic              out_valid,
  output logic              busy,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  state_e             state, state_nxt;
  logic [WIDTH-1:0]   dataout_nxt, hi_nxt, lo_nxt;
  logic               out_valid_nxt, busy_nxt;
  logic               accept_c, start_c, step_c, last_c;
  logic [2*WIDTH-1:0] product_c;

  assign in_ready = ~busy;
  assign accept_c = valid_in & ~busy;

  multu_seq #(.WIDTH(WIDTH)) u_multu (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_c),
    .step      (step_c),
    .a         (a),
    .b         (b),
    .last_c    (last_c),
    .product_c (product_c)
  );

  // Next-state and registered-output values.
  always_comb begin
    state_nxt     = state;
    dataout_nxt   = dataout;
    out_valid_nxt = 1'b0;
    busy_nxt      = busy;
    hi_nxt        = hi;
    lo_nxt        = lo;
    start_c       = 1'b0;
    step_c        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept_c) begin
          if (Signal == FN_MULTU) begin
            start_c   = 1'b1;
            busy_nxt  = 1'b1;
            state_nxt = S_MUL;
          end else begin
            out_valid_nxt = 1'b1;
            case (Signal)
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: dataout_nxt = alu_result;
              FN_SRL:  dataout_nxt = shift_result;
              FN_MFHI: dataout_nxt = hi;
              FN_MFLO: dataout_nxt = lo;
              default: dataout_nxt = '0;
            endcase
          end
        end
      end
      S_MUL: begin
        step_c = 1'b1;
        if (last_c) begin
          {hi_nxt, lo_nxt} = product_c;
          dataout_nxt      = product_c[WIDTH-1:0];
          out_valid_nxt    = 1'b1;
          busy_nxt         = 1'b0;
          state_nxt        = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      dataout   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      state     <= state_nxt;
      dataout   <= dataout_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
      hi        <= hi_nxt;
      lo        <= lo_nxt;
    end
  end

endmodule

// File: tb/tb_exec_result_stage.sv
// Scoreboard bench for exec_result_stage: expected dataout values are queued at
// issue and compared whenever out_valid is seen; HI/LO and busy timing checked directly.
module tb_exec_result_stage;
  import exec_pkg::*;

  localparam int unsigned W = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [5:0]      Signal = '0;
  logic            valid_in = 1'b0;
  logic            in_ready;
  logic [W-1:0]    alu_result = '0, shift_result = '0, a = '0, b = '0;
  logic [W-1:0]    dataout, hi, lo;
  logic            out_valid, busy;

  int              n_checks = 0;
  int              n_fail = 0;
  logic [W-1:0]    sb[$];
  logic [W-1:0]    model_hi = '0, model_lo = '0, last_dout = '0;

  always #5 clk = ~clk;

  exec_result_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .Signal(Signal), .valid_in(valid_in),
    .in_ready(in_ready), .alu_result(alu_result), .shift_result(shift_result),
    .a(a), .b(b), .dataout(dataout), .out_valid(out_valid), .busy(busy),
    .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) chk("unexpected_out_valid", 64'(dataout), 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("dataout", 64'(dataout), 64'(sb.pop_front()));
    end
  end

  // Drive one accepted operation for one edge and queue its expected result.
  task automatic send(input logic [5:0] fn, input logic [W-1:0] ar, input logic [W-1:0] sr,
                      input logic [W-1:0] aa, input logic [W-1:0] bb);
    logic [W-1:0]   exp;
    logic [2*W-1:0] p;
    @(negedge clk);
    Signal = fn; alu_result = ar; shift_result = sr; a = aa; b = bb; valid_in = 1'b1;
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: exp = ar;
      FN_SRL:  exp = sr;
      FN_MFHI: exp = model_hi;
      FN_MFLO: exp = model_lo;
      FN_MULTU: begin
        p = 64'(aa) * 64'(bb);
        model_hi = p[2*W-1:W];
        model_lo = p[W-1:0];
        exp = model_lo;
      end
      default: exp = '0;
    endcase
    sb.push_back(exp);
    last_dout = exp;
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  // MULTU with busy-length count; optionally inject a request at busy cycle inj.
  task automatic mul_run(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input int inj);
    int n;
    logic [W-1:0] hold;
    bit done;
    n = 0; done = 0;
    hold = last_dout;
    send(FN_MULTU, '0, '0, aa, bb);
    last_dout = hold;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      if (!busy) begin done = 1; break; end
      n++;
      if (n == inj) begin
        chk({tag, "_ready_low"}, 64'(in_ready), 64'd0);
        chk({tag, "_drop_dataout"}, 64'(dataout), 64'(hold));
        Signal = FN_ADD; alu_result = 32'hDEAD_BEEF; a = '0; b = '0; valid_in = 1'b1;
      end
    end
    last_dout = model_lo;
    chk({tag, "_completed"}, 64'(done), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(n), 64'd32);
    chk({tag, "_hi"}, 64'(hi), 64'(model_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(model_lo));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    chk("reset_dataout", 64'(dataout), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("ready_idle", 64'(in_ready), 64'd1);

    // Back-to-back single-cycle ops.
    send(FN_SRL, '0, 32'h0000_0F00, '0, '0);
    send(FN_ADD, 32'h1234_5678, '0, '0, '0);
    send(FN_OR,  32'hA5A5_0000, 32'h1, '0, '0);
    repeat (2) @(negedge clk);
    chk("out_valid_pulse_ends", 64'(out_valid), 64'd0);
    chk("dataout_holds", 64'(dataout), 64'hA5A5_0000);

    mul_run("mul7x6", 32'd7, 32'd6, -1);
    send(FN_MFLO, '0, '0, '0, '0);
    send(FN_MFHI, '0, '0, '0, '0);

    mul_run("mulmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    send(FN_MFHI, '0, '0, '0, '0);
    send(FN_MFLO, '0, '0, '0, '0);

    // Request during multiply is dropped; a/b changes ignored.
    mul_run("muldrop", 32'h0001_2345, 32'h0ABC_DEF1, 10);

    // Establish hi=5, then abort a multiply with reset.
    mul_run("mulhi5", 32'h5000_0000, 32'h0000_0010, -1);
    chk("hi_is_5", 64'(hi), 64'd5);
    send(FN_MULTU, '0, '0, 32'd3, 32'd9);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    model_hi = '0; model_lo = '0; last_dout = '0;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_dataout", 64'(dataout), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mul_run("mulpost", 32'h0001_0000, 32'h0003_0000, -1);
    send(FN_MFHI, '0, '0, '0, '0);

    // Undefined code returns zero, HI/LO untouched.
    send(6'd63, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0);
    send(FN_ADD, 32'h0000_0001, '0, '0, '0);
    send(6'd63, 32'h1111_1111, '0, '0, '0);
    repeat (2) @(negedge clk);
    chk("undef_hi", 64'(hi), 64'(model_hi));
    chk("undef_lo", 64'(lo), 64'(model_lo));
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_result_stage.md
# exec_result_stage

Execute-stage result register for the single-cycle-ALU datapath. Sits directly downstream of the combinational ALU and the logical right shifter. Each accepted operation selects and registers one result by the 6-bit function code `Signal`: ALU result, shifter result, HI or LO. It also runs a 32-iteration sequential unsigned shift-add multiplier (MULTU) that writes the HI/LO pair.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; the multiplier product is 2·WIDTH.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Signal`  in  6  MIPS funct code of the operation.
- `valid_in`  in  1  operation request; accepted only when `in_ready`=1.
- `in_ready`  out  1  = ~`busy`.
- `alu_result`  in  WIDTH  ALU output (ADD/SUB/AND/OR/SLT).
- `shift_result`  in  WIDTH  shifter output (SRL).
- `a`, `b`  in  WIDTH each  MULTU multiplicand and multiplier.
- `dataout`  out  WIDTH  registered result.
- `out_valid`  out  1  one-cycle pulse: `dataout` was updated.
- `busy`  out  1  multiply in progress.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO registers.

## Operation
- Function codes (decimal): ADD 32, SUB 34, AND 36, OR 37, SLT 42, SRL 2, MULTU 25, MFHI 16, MFLO 18.
- Accept = `valid_in` & `in_ready`. A request with `in_ready`=0 is dropped: no state change, no `out_valid`.
- FSM states: IDLE, MUL.
- In IDLE, on accept:
  - ALU codes: `dataout` ← `alu_result`.
  - SRL: `dataout` ← `shift_result`.
  - MFHI: `dataout` ← `hi`.
  - MFLO: `dataout` ← `lo`.
  - Any undefined code: `dataout` ← 0.
  - In all of the above cases, `out_valid` pulses and the FSM stays in IDLE.
- MULTU accept:
  - Load `mcand` ← `a` and `prod` (2·WIDTH+1 bits) ← {0, 0…0, `b`}.
  - Clear `cnt` (5 bits); enter MUL; `busy`=1.
- MUL iteration, once per cycle:
  - If `prod[0]`=1, the upper WIDTH+1 bits ← upper WIDTH+1 bits + `mcand`.
  - Then shift `prod` right by 1; `cnt`++.
- When `cnt`=31 completes:
  - `{hi,lo}` ← final product; `dataout` ← product low word; `out_valid` pulses.
  - Return to IDLE.
- All arithmetic is unsigned. The carry bit of the WIDTH+1 accumulator is never lost.
- `hi`/`lo` change only at MULTU completion or reset. MFHI/MFLO never modify them.
- Reset (any time, including mid-MUL):
  - `dataout`=0, `out_valid`=0, `busy`=0, `hi`=0, `lo`=0, state IDLE.
  - An aborted multiply leaves no partial HI/LO.

## Timing
- Non-multiply latency: accept at edge E0 → `dataout`/`out_valid` valid after E0. `in_ready` stays 1, so back-to-back accepts every cycle are legal.
- Multiply:
  - Accept at E0; `busy`=1 after E0.
  - Iterations occur at E1..E32.
  - At E32: `hi`/`lo`/`dataout` update, `out_valid`=1 for the following cycle, `busy`=0.
  - The next accept is possible at E33; 33 cycles accept-to-accept.
- MFHI accepted at E33 returns the new HI (no bypass hazard).
- `Signal`/`a`/`b` are sampled only at accept. Changes during MUL are ignored.

## Structure
- Shared package `exec_pkg`: funct localparams (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SRL, FN_MULTU, FN_MFHI, FN_MFLO) and the state enum {S_IDLE, S_MUL}.
- One natural sub-module: `multu_seq`, the shift-add datapath (`mcand`, `prod`, `cnt`, done strobe). The top holds the FSM, result mux, HI/LO and output registers.

## Test plan
- SRL, `shift_result`=0x0000_0F00, `valid_in` one cycle → after 1 edge `dataout`=0x0000_0F00, `out_valid` one cycle; then ADD with `alu_result`=0x1234_5678 on the next cycle → `dataout`=0x1234_5678.
- MULTU `a`=7, `b`=6 → `busy` exactly 32 cycles after accept; then `hi`=0, `lo`=42, `dataout`=42; MFLO → 42.
- MULTU `a`=`b`=0xFFFF_FFFF → `hi`=0xFFFF_FFFE, `lo`=0x0000_0001; MFHI → `dataout`=0xFFFF_FFFE (checks the carry bit).
- ADD issued with `valid_in`=1 during MUL (cycle 10) → dropped: no `out_valid`, `dataout` unchanged, product still correct.
- `rst_n` low at MUL cycle 10 after a prior `hi`=5 → `busy`=0, `hi`=`lo`=`dataout`=0 immediately (asynchronous); a new MULTU after release computes correctly.
- Undefined `Signal`=63 → `dataout`=0, `out_valid` pulse, `hi`/`lo` untouched.
